// File: rtl/cdc_pkg.sv
// Shared definitions for the req/ack clock-domain-crossing handshake pair.
// Contents:
//   cdc_state_e          responder FSM state (2-bit)
//   CDC_SYNC_STAGES_DEF  default synchroniser depth
package cdc_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    DELIVER = 2'd2,
    ACK     = 2'd3
  } cdc_state_e;

  localparam int unsigned CDC_SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/cdc_ack_responder_b_if.sv
// Handshake and status bundle of the clk_b-side CDC responder.
// Signals:
//   req_a_in, data_a_in   request level and held word from the clk_a initiator
//   ack_b_out             acknowledge level back to clk_a
//   data_out, vld_out     word offered to the local consumer
//   rdy_in                local consumer ready
//   busy_out              responder not idle
//   xfer_cnt_out          completed transfers (16-bit, wrapping)
//   proto_err_out         sticky: request dropped before acknowledge
// Modports: slave = responder, master = initiator / consumer / observer side.
interface cdc_ack_responder_b_if #(
  parameter int unsigned DATA_W = 8
);
  logic              req_a_in;
  logic [DATA_W-1:0] data_a_in;
  logic              ack_b_out;
  logic [DATA_W-1:0] data_out;
  logic              vld_out;
  logic              rdy_in;
  logic              busy_out;
  logic [15:0]       xfer_cnt_out;
  logic              proto_err_out;

  modport slave (
    input  req_a_in, data_a_in, rdy_in,
    output ack_b_out, data_out, vld_out, busy_out, xfer_cnt_out, proto_err_out
  );

  modport master (
    output req_a_in, data_a_in, rdy_in,
    input  ack_b_out, data_out, vld_out, busy_out, xfer_cnt_out, proto_err_out
  );
endinterface

// File: rtl/cdc_sync_bit.sv
// Single-bit multi-flop synchroniser with asynchronous active-low reset.
// Ports:
//   i_clk    destination clock
//   i_rst_n  asynchronous active-low reset, clears every stage
//   i_d      asynchronous input level
//   o_q      synchronised level, SYNC_STAGES cycles of latency
module cdc_sync_bit
  import cdc_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = CDC_SYNC_STAGES_DEF
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [SYNC_STAGES-1:0] r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/cdc_ack_responder_b.sv
// clk_b-side responder of the four-phase req/ack CDC handshake.
// Synchronises the request, captures the held word, waits PROC_TICKS cycles, offers the word
// with valid/ready, then raises a registered acknowledge until the request is withdrawn.
// Ports:
//   clk_b     destination clock
//   reset_in  asynchronous active-low reset
//   bus       handshake/status bundle (slave side)
module cdc_ack_responder_b
  import cdc_pkg::*;
#(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned SYNC_STAGES = CDC_SYNC_STAGES_DEF,
  parameter int unsigned PROC_TICKS  = 3
) (
  input  logic                  clk_b,
  input  logic                  reset_in,
  cdc_ack_responder_b_if.slave  bus
);

  localparam logic [3:0] PROC_CNT = 4'(PROC_TICKS);

  logic              w_req_s;
  cdc_state_e        r_state, w_state_d;
  logic [3:0]        r_cnt, w_cnt_d;
  logic [DATA_W-1:0] r_data, w_data_d;
  logic              r_vld, w_vld_d;
  logic              r_ack, w_ack_d;
  logic              w_xfer_inc;
  logic              w_proto_viol;
  logic [15:0]       r_xfer_cnt;
  logic              r_proto_err;

  cdc_sync_bit #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_req_sync (
    .i_clk  (clk_b),
    .i_rst_n(reset_in),
    .i_d    (bus.req_a_in),
    .o_q    (w_req_s)
  );

  always_comb begin
    w_state_d    = r_state;
    w_cnt_d      = r_cnt;
    w_data_d     = r_data;
    w_vld_d      = r_vld;
    w_ack_d      = r_ack;
    w_xfer_inc   = 1'b0;
    w_proto_viol = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_req_s) begin
          // data_a_in is held stable by the initiator while req is high, so a
          // plain sample here is safe without synchronisation.
          w_data_d = bus.data_a_in;
          w_cnt_d  = PROC_CNT;
          if (PROC_TICKS == 0) begin
            w_state_d = DELIVER;
            w_vld_d   = 1'b1;
          end else begin
            w_state_d = WAIT;
          end
        end
      end
      WAIT: begin
        w_cnt_d      = r_cnt - 4'd1;
        w_proto_viol = !w_req_s;
        if (r_cnt == 4'd1) begin
          w_state_d = DELIVER;
          w_vld_d   = 1'b1;
        end
      end
      DELIVER: begin
        w_proto_viol = !w_req_s;
        if (r_vld && bus.rdy_in) begin
          w_vld_d    = 1'b0;
          w_ack_d    = 1'b1;
          w_xfer_inc = 1'b1;
          w_state_d  = ACK;
        end
      end
      ACK: begin
        if (!w_req_s) begin
          w_ack_d   = 1'b0;
          w_state_d = IDLE;
        end
      end
      default: w_state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_b or negedge reset_in) begin
    if (!reset_in) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_data  <= '0;
      r_vld   <= 1'b0;
      r_ack   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_data  <= w_data_d;
      r_vld   <= w_vld_d;
      r_ack   <= w_ack_d;
    end
  end

  always_ff @(posedge clk_b or negedge reset_in) begin
    if (!reset_in) begin
      r_xfer_cnt  <= '0;
      r_proto_err <= 1'b0;
    end else begin
      if (w_xfer_inc) begin
        r_xfer_cnt <= r_xfer_cnt + 16'd1;
      end
      if (w_proto_viol) begin
        r_proto_err <= 1'b1;
      end
    end
  end

  assign bus.ack_b_out     = r_ack;
  assign bus.data_out      = r_data;
  assign bus.vld_out       = r_vld;
  assign bus.busy_out      = (r_state != IDLE);
  assign bus.xfer_cnt_out  = r_xfer_cnt;
  assign bus.proto_err_out = r_proto_err;

endmodule
